// File: rtl/mbank_bist.sv
// March-test initiator/checker for mbank_controller: writes addr^SEED, reads it back, reports mismatches.
// Optional inverted descending passes (P2/P3) are enabled by defining MBANK_BIST_INV_PASS_EN.
module mbank_bist #(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] SEED    = DATA_W'(8'hA5),
    parameter int                TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    input  logic              busy,
    input  logic              ready,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef MBANK_BIST_INV_PASS_EN
    localparam int PW = 2;
`else
    localparam int PW = 1;
`endif

    state_t            state;
    logic [PW-1:0]     phase;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] dout_q;

    logic [PW-1:0]     nxt_phase;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] nxt_step;
    logic [ADDR_W-1:0] nxt_start;
    logic              nxt_inv;
    logic              at_end;
    logic              last_phase;

    logic unused_ready;
    assign unused_ready = ready;

    function automatic logic [DATA_W-1:0] pattern(input logic inv, input logic [ADDR_W-1:0] a);
        pattern = (DATA_W'(a) ^ SEED) ^ {DATA_W{inv}};
    endfunction

    // Address/phase sequencing for the access that follows the current one.
    always_comb begin
`ifdef MBANK_BIST_INV_PASS_EN
        end_addr   = phase[1] ? '0 : '1;
        nxt_step   = phase[1] ? addr - 1'b1 : addr + 1'b1;
        last_phase = &phase;
`else
        end_addr   = '1;
        nxt_step   = addr + 1'b1;
        last_phase = phase[0];
`endif
        at_end    = (addr == end_addr);
        nxt_phase = at_end ? phase + 1'b1 : phase;
`ifdef MBANK_BIST_INV_PASS_EN
        nxt_start = nxt_phase[1] ? '1 : '0;
        nxt_inv   = nxt_phase[1];
`else
        nxt_start = '0;
        nxt_inv   = 1'b0;
`endif
        nxt_addr = at_end ? nxt_start : nxt_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= '0;
            tcnt        <= '0;
            dout_q      <= '0;
            req         <= 1'b0;
            we          <= 1'b0;
            addr        <= '0;
            din         <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        fail_addr   <= '0;
                        fail_data   <= '0;
                        timeout_err <= 1'b0;
                        running     <= 1'b1;
                        phase       <= '0;
                        addr        <= '0;
                        we          <= 1'b1;
                        din         <= pattern(1'b0, '0);
                        req         <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    req   <= 1'b0;
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!busy) begin
                        dout_q <= dout;
                        state  <= we ? S_NEXT : S_CHECK;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        running     <= 1'b0;
                        pass        <= 1'b0;
                        state       <= S_FINISH;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    // din still holds this address's pattern, which is the expected read value.
                    if (dout_q != din) begin
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        if (err_count == 8'd0) begin
                            fail_addr <= addr;
                            fail_data <= dout_q;
                        end
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (at_end && last_phase) begin
                        done    <= 1'b1;
                        running <= 1'b0;
                        pass    <= (err_count == 8'd0) && !timeout_err;
                        state   <= S_FINISH;
                    end else begin
                        phase <= nxt_phase;
                        addr  <= nxt_addr;
                        we    <= ~nxt_phase[0];
                        din   <= pattern(nxt_inv, nxt_addr);
                        req   <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbank_bist.sv
// Self-checking bench for mbank_bist: randomized-latency controller model plus a march reference model.
// Honours MBANK_BIST_INV_PASS_EN to expect the four-pass sequence.
module tb_mbank_bist;

    localparam int          AW   = 5;
    localparam int          DW   = 8;
    localparam int          N    = 1 << AW;
    localparam logic [7:0]  SEED = 8'hA5;
`ifdef MBANK_BIST_INV_PASS_EN
    localparam int NPH = 4;
`else
    localparam int NPH = 2;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          busy;
    logic          ready;
    logic          running;
    logic          done;
    logic          pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    mbank_bist #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .SEED   (SEED),
        .TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .busy       (busy),
        .ready      (ready),
        .running    (running),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign ready = ~busy;

    // Controller model: 0 = correct, 1 = one address corrupted in the first read pass,
    // 2 = every read returns FF, 3 = busy sticks high on access number stuck_idx.
    int         mode = 0;
    int         faddr = 0;
    logic [7:0] fdata = 8'h00;
    int         stuck_idx = 0;
    logic [7:0] mem[N];
    int         acc_cnt = 0;
    int         rd_idx = 0;
    int         lat_sum = 0;
    int         viol = 0;
    int         lat;
    logic [AW-1:0] a_c;
    logic       we_c;
    logic [7:0] d_c;
    logic       req_prev;

    function automatic logic [7:0] fault_val(input int ri, input int a, input logic [7:0] mv);
        case (mode)
            1:       return (ri < N && a == faddr) ? fdata : mv;
            2:       return 8'hFF;
            default: return mv;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int l;
        if (rst) begin
            busy     <= 1'b0;
            lat      <= 0;
            dout     <= '0;
            req_prev <= 1'b0;
        end else begin
            req_prev <= req;
            if (req && req_prev) viol <= viol + 1;
            if (busy && (addr !== a_c || we !== we_c || din !== d_c)) viol <= viol + 1;
            if (start && !running) begin
                acc_cnt <= 0;
                rd_idx  <= 0;
                lat_sum <= 0;
                viol    <= 0;
                busy    <= 1'b0;
            end else if (req) begin
                l = (mode == 3 && acc_cnt == stuck_idx) ? -1 : int'($urandom_range(0, 3));
                acc_cnt <= acc_cnt + 1;
                a_c     <= addr;
                we_c    <= we;
                d_c     <= din;
                if (l == 0) begin
                    if (we) mem[addr] <= din;
                    else begin
                        dout   <= fault_val(rd_idx, int'(addr), mem[addr]);
                        rd_idx <= rd_idx + 1;
                    end
                end else begin
                    busy <= 1'b1;
                    lat  <= l;
                    if (l > 0) lat_sum <= lat_sum + l;
                end
            end else if (busy && lat > 0) begin
                if (lat == 1) begin
                    busy <= 1'b0;
                    if (we_c) mem[a_c] <= d_c;
                    else begin
                        dout   <= fault_val(rd_idx, int'(a_c), mem[a_c]);
                        rd_idx <= rd_idx + 1;
                    end
                end
                lat <= lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit inject, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = inject && (cyc == 40 || cyc == 100);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, {26'd0, req, we, running, done, pass, timeout_err}, 32'd0);
        chk({tag, ".addr"}, 32'(addr), 32'd0);
        chk({tag, ".din"}, 32'(din), 32'd0);
        chk({tag, ".err"}, 32'(err_count), 32'd0);
        chk({tag, ".fail"}, {19'd0, fail_addr, fail_data}, 32'd0);
    endtask

    // Full run checked against a march reference computed directly from the pass definitions.
    task automatic run_check(input string tag, input bit inject);
        int cyc, e, fa, fd, ri, a, reads;
        bit ok;
        logic [7:0] m[N];
        logic [7:0] pat, v;
        pulse_start();
        chk({tag, ".running"}, 32'(running), 32'd1);
        chk({tag, ".done_clr"}, 32'(done), 32'd0);
        wait_done(inject, cyc, ok);
        chk({tag, ".finished"}, 32'(ok), 32'd1);
        e = 0; fa = 0; fd = 0; ri = 0; reads = 0;
        for (int p = 0; p < NPH; p++) begin
            for (int k = 0; k < N; k++) begin
                a   = (p < 2) ? k : N - 1 - k;
                pat = 8'(a) ^ SEED;
                if (p >= 2) pat = ~pat;
                if (p % 2 == 0) m[a] = pat;
                else begin
                    v = fault_val(ri, a, m[a]);
                    ri++;
                    reads++;
                    if (v != pat) begin
                        if (e == 0) begin
                            fa = a;
                            fd = int'(v);
                        end
                        if (e < 255) e++;
                    end
                end
            end
        end
        chk({tag, ".err_count"}, 32'(err_count), 32'(e));
        chk({tag, ".fail_addr"}, 32'(fail_addr), 32'(fa));
        chk({tag, ".fail_data"}, 32'(fail_data), 32'(fd));
        chk({tag, ".pass"}, 32'(pass), 32'(e == 0));
        chk({tag, ".timeout"}, 32'(timeout_err), 32'd0);
        chk({tag, ".running_end"}, 32'(running), 32'd0);
        chk({tag, ".accesses"}, 32'(acc_cnt), 32'(NPH * N));
        chk({tag, ".cycles"}, 32'(cyc), 32'(3 * NPH * N + reads + lat_sum));
        chk({tag, ".protocol"}, 32'(viol), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".done_held"}, {30'd0, done, req}, 32'd2);
    endtask

    initial begin : main
        int cyc, guard;
        bit ok;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        mode = 0;
        run_check("clean", 1'b0);

        mode = 1; faddr = 5; fdata = 8'h00;
        run_check("addr5_zero", 1'b0);

        mode = 2;
        run_check("stuck_ff", 1'b0);

        for (int r = 0; r < 3; r++) begin
            mode  = 1;
            faddr = int'($urandom_range(0, N - 1));
            fdata = 8'($urandom);
            run_check($sformatf("rand_fault%0d", r), 1'b0);
        end

        mode = 0;
        run_check("start_while_running", 1'b1);

        mode = 3; stuck_idx = 2;
        pulse_start();
        wait_done(1'b0, cyc, ok);
        chk("tmo.finished", 32'(ok), 32'd1);
        chk("tmo.flags", {28'd0, timeout_err, done, pass, running}, 32'b1100);
        chk("tmo.accesses", 32'(acc_cnt), 32'd3);
        repeat (10) @(posedge clk);
        #1;
        chk("tmo.req_quiet", {31'd0, req}, 32'd0);
        chk("tmo.accesses_after", 32'(acc_cnt), 32'd3);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;

        mode = 0;
        pulse_start();
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(req && !we && addr == 5'd10) && guard < 4000);
        chk("midrst.reached", 32'(guard < 4000), 32'd1);
        rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk) rst = 1'b0;
        run_check("after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
